// File: rtl/dr32e_pkg.sv
// Shared RV32E front-end definitions: opcodes, branch-history counter states
// and immediate extractors for the fetch-side predictor.
package dr32e_pkg;

  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    BHT_SNT = 2'b00,
    BHT_WNT = 2'b01,
    BHT_WT  = 2'b10,
    BHT_ST  = 2'b11
  } bht_state_e;

  // J-type immediate, sign-extended, bit 0 always zero.
  function automatic logic [31:0] imm_j(input logic [31:0] instr);
    return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

  // B-type immediate, sign-extended, bit 0 always zero.
  function automatic logic [31:0] imm_b(input logic [31:0] instr);
    return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/dr32e_bht.sv
// Branch history table: array of 2-bit saturating counters with one
// combinational read port and one registered write (train) port.
module dr32e_bht
  import dr32e_pkg::*;
#(
  parameter int unsigned ENTRIES     = 16,
  parameter bht_state_e  RESET_STATE = BHT_WNT,
  localparam int unsigned IDX_W      = $clog2(ENTRIES)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [IDX_W-1:0] rd_idx,
  output bht_state_e       rd_state,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  bht_state_e cnt_q [ENTRIES];
  bht_state_e wr_next_s;
  logic [1:0] wr_cur_s;

  // Read returns the pre-update value; there is no write-to-read bypass.
  assign rd_state = cnt_q[rd_idx];
  assign wr_cur_s = cnt_q[wr_idx];

  // Saturating increment / decrement of the counter being trained.
  always_comb begin
    wr_next_s = bht_state_e'(wr_cur_s);
    if (wr_taken) begin
      if (wr_cur_s != 2'b11) begin
        wr_next_s = bht_state_e'(wr_cur_s + 2'd1);
      end else begin
        wr_next_s = BHT_ST;
      end
    end else begin
      if (wr_cur_s != 2'b00) begin
        wr_next_s = bht_state_e'(wr_cur_s - 2'd1);
      end else begin
        wr_next_s = BHT_SNT;
      end
    end
  end

  // Counter storage with asynchronous reset of every entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        cnt_q[i] <= RESET_STATE;
      end
    end else if (wr_en) begin
      cnt_q[wr_idx] <= wr_next_s;
    end
  end

endmodule

// File: rtl/dr32e_branch_predict.sv
// Fetch-side branch predictor: decodes the fetched word and predicts
// taken/target in the same cycle (JAL always, BRANCH via the BHT).
module dr32e_branch_predict
  import dr32e_pkg::*;
#(
  parameter int unsigned BHT_ENTRIES = 16,
  parameter logic [1:0]  BHT_RESET   = 2'b01
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] fetch_rdata_i,
  input  logic [31:0] fetch_pc_i,
  input  logic        fetch_valid_i,
  output logic        predict_branch_taken_o,
  output logic [31:0] predict_branch_pc_o,
  input  logic        upd_valid_i,
  input  logic [31:0] upd_pc_i,
  input  logic        upd_taken_i
);

  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

  bht_state_e  rd_state_s;
  logic [6:0]  opcode_s;
  logic        pred_taken_s;
  logic [31:0] pred_pc_s;
  logic        unused_upd_pc_s;

  assign opcode_s        = fetch_rdata_i[6:0];
  assign unused_upd_pc_s = ^{upd_pc_i[31:IDX_W+2], upd_pc_i[1:0]};

  dr32e_bht #(
    .ENTRIES    (BHT_ENTRIES),
    .RESET_STATE(bht_state_e'(BHT_RESET))
  ) u_bht (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .rd_idx  (fetch_pc_i[IDX_W+1:2]),
    .rd_state(rd_state_s),
    .wr_en   (upd_valid_i),
    .wr_idx  (upd_pc_i[IDX_W+1:2]),
    .wr_taken(upd_taken_i)
  );

  // Invalid fetch forces zeros so an undefined instruction word cannot leak out.
  always_comb begin
    pred_taken_s = 1'b0;
    pred_pc_s    = 32'h0;
    if (fetch_valid_i) begin
      case (opcode_s)
        OPCODE_JAL: begin
          pred_taken_s = 1'b1;
          pred_pc_s    = fetch_pc_i + imm_j(fetch_rdata_i);
        end
        OPCODE_BRANCH: begin
          pred_taken_s = rd_state_s[1];
          pred_pc_s    = fetch_pc_i + imm_b(fetch_rdata_i);
        end
        default: begin
          pred_taken_s = 1'b0;
          pred_pc_s    = 32'h0;
        end
      endcase
    end else begin
      pred_taken_s = 1'b0;
      pred_pc_s    = 32'h0;
    end
  end

  assign predict_branch_taken_o = pred_taken_s;
  assign predict_branch_pc_o    = pred_pc_s;

endmodule

// File: tb/tb_dr32e_branch_predict.sv
// Self-checking bench for dr32e_branch_predict: directed scenarios plus
// randomized traffic against a counter-array reference model.
module tb_dr32e_branch_predict;

  localparam logic [31:0] BEQ  = 32'h00000463;
  localparam logic [31:0] JAL  = 32'hFF9FF06F;
  localparam logic [31:0] JALR = 32'h00008067;
  localparam logic [31:0] NOP  = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic [31:0] fetch_rdata_i;
  logic [31:0] fetch_pc_i;
  logic        fetch_valid_i;
  logic        predict_branch_taken_o;
  logic [31:0] predict_branch_pc_o;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic        upd_taken_i;

  int cnt_m [16];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dr32e_branch_predict dut (
    .clk_i                 (clk),
    .rst_ni                (rst_ni),
    .fetch_rdata_i         (fetch_rdata_i),
    .fetch_pc_i            (fetch_pc_i),
    .fetch_valid_i         (fetch_valid_i),
    .predict_branch_taken_o(predict_branch_taken_o),
    .predict_branch_pc_o   (predict_branch_pc_o),
    .upd_valid_i           (upd_valid_i),
    .upd_pc_i              (upd_pc_i),
    .upd_taken_i           (upd_taken_i)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) cnt_m[i] = 1;
  endtask

  // Reference prediction: immediates assembled arithmetically from field weights.
  task automatic model_pred(input logic [31:0] rd, input logic [31:0] pc, input logic v,
                            output logic t, output logic [31:0] tg);
    int imm;
    int idx;
    t   = 1'b0;
    tg  = 32'h0;
    idx = int'((pc >> 2) & 32'd15);
    if (v && rd[6:0] == 7'b1101111) begin
      imm = rd[31] ? -(1 << 20) : 0;
      imm += int'(rd[19:12]) * 4096 + int'(rd[20]) * 2048 + int'(rd[30:21]) * 2;
      t  = 1'b1;
      tg = pc + 32'(imm);
    end else if (v && rd[6:0] == 7'b1100011) begin
      imm = rd[31] ? -4096 : 0;
      imm += int'(rd[7]) * 2048 + int'(rd[30:25]) * 32 + int'(rd[11:8]) * 2;
      t  = (cnt_m[idx] >= 2);
      tg = pc + 32'(imm);
    end
  endtask

  task automatic model_train(input logic [31:0] pc, input logic tk);
    int idx;
    idx = int'((pc >> 2) & 32'd15);
    if (tk) cnt_m[idx] = (cnt_m[idx] == 3) ? 3 : cnt_m[idx] + 1;
    else    cnt_m[idx] = (cnt_m[idx] == 0) ? 0 : cnt_m[idx] - 1;
  endtask

  // One cycle starting at a negedge: drive, check against model, clock, train model.
  task automatic cyc(input string tag, input logic [31:0] rd, input logic [31:0] pc, input logic v,
                     input logic uv, input logic [31:0] upc, input logic ut,
                     output logic got_t, output logic [31:0] got_pc);
    logic        et;
    logic [31:0] ep;
    fetch_rdata_i = rd;
    fetch_pc_i    = pc;
    fetch_valid_i = v;
    upd_valid_i   = uv;
    upd_pc_i      = upc;
    upd_taken_i   = ut;
    #2;
    model_pred(rd, pc, v, et, ep);
    got_t  = predict_branch_taken_o;
    got_pc = predict_branch_pc_o;
    check({tag, "_taken_m"}, {31'h0, got_t}, {31'h0, et});
    if (et) check({tag, "_pc_m"}, got_pc, ep);
    @(posedge clk);
    if (uv) model_train(upc, ut);
    @(negedge clk);
  endtask

  initial begin
    logic        gt;
    logic [31:0] gp;
    logic [31:0] rd;
    logic [31:0] pc;
    rst_ni        = 1'b0;
    fetch_rdata_i = 32'h0;
    fetch_pc_i    = 32'h0;
    fetch_valid_i = 1'b0;
    upd_valid_i   = 1'b0;
    upd_pc_i      = 32'h0;
    upd_taken_i   = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_taken", {31'h0, predict_branch_taken_o}, 32'h0);
    check("rst_pc", predict_branch_pc_o, 32'h0);
    rst_ni = 1'b1;

    cyc("t1", BEQ, 32'h100, 1'b1, 1'b0, 32'h0, 1'b0, gt, gp);
    check("t1_taken", {31'h0, gt}, 32'h0);

    cyc("t2u1", NOP, 32'h0, 1'b0, 1'b1, 32'h100, 1'b1, gt, gp);
    cyc("t2u2", NOP, 32'h0, 1'b0, 1'b1, 32'h100, 1'b1, gt, gp);
    cyc("t2", BEQ, 32'h100, 1'b1, 1'b0, 32'h0, 1'b0, gt, gp);
    check("t2_taken", {31'h0, gt}, 32'h1);
    check("t2_pc", gp, 32'h108);
    cyc("t2u3", NOP, 32'h0, 1'b0, 1'b1, 32'h100, 1'b1, gt, gp);

    cyc("t3j", JAL, 32'h200, 1'b1, 1'b0, 32'h0, 1'b0, gt, gp);
    check("t3_jal_taken", {31'h0, gt}, 32'h1);
    check("t3_jal_pc", gp, 32'h1F8);
    cyc("t3r", JALR, 32'h200, 1'b1, 1'b0, 32'h0, 1'b0, gt, gp);
    check("t3_jalr_taken", {31'h0, gt}, 32'h0);
    check("t3_jalr_pc", gp, 32'h0);

    cyc("t4a", BEQ, 32'h100, 1'b1, 1'b1, 32'h100, 1'b0, gt, gp);
    check("t4_same_cycle", {31'h0, gt}, 32'h1);
    cyc("t4b", BEQ, 32'h100, 1'b1, 1'b1, 32'h100, 1'b0, gt, gp);
    check("t4_weak_t", {31'h0, gt}, 32'h1);
    cyc("t4c", BEQ, 32'h100, 1'b1, 1'b0, 32'h0, 1'b0, gt, gp);
    check("t4_weak_nt", {31'h0, gt}, 32'h0);

    cyc("t5u1", NOP, 32'h0, 1'b0, 1'b1, 32'h140, 1'b1, gt, gp);
    cyc("t5u2", NOP, 32'h0, 1'b0, 1'b1, 32'h140, 1'b1, gt, gp);
    cyc("t5", BEQ, 32'h100, 1'b1, 1'b0, 32'h0, 1'b0, gt, gp);
    check("t5_alias", {31'h0, gt}, 32'h1);

    // Asynchronous reset mid-cycle, away from any clock edge.
    fetch_rdata_i = BEQ;
    fetch_pc_i    = 32'h100;
    fetch_valid_i = 1'b1;
    upd_valid_i   = 1'b0;
    #1;
    check("t6_pre_rst", {31'h0, predict_branch_taken_o}, 32'h1);
    rst_ni = 1'b0;
    model_reset();
    #1;
    check("t6_async_rst", {31'h0, predict_branch_taken_o}, 32'h0);
    check("t6_rst_pc", predict_branch_pc_o, 32'h108);
    fetch_valid_i = 1'b0;
    fetch_rdata_i = 'x;
    #1;
    check("t6_x_taken", {31'h0, predict_branch_taken_o}, 32'h0);
    check("t6_x_pc", predict_branch_pc_o, 32'h0);
    @(negedge clk);
    rst_ni = 1'b1;

    for (int n = 0; n < 400; n++) begin
      rd = $urandom;
      case ($urandom_range(0, 3))
        0:       rd[6:0] = 7'b1101111;
        1:       rd[6:0] = 7'b1100011;
        2:       rd[6:0] = 7'b1100111;
        default: rd[6:0] = rd[6:0];
      endcase
      pc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FF00 | 32'($urandom_range(0, 255)))
                                       : 32'($urandom_range(0, 1023));
      cyc("rnd", rd, pc, 1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)),
          32'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)), gt, gp);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
